// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: two writeback sources,
// the issue-stage reservation port, and the registered write command plus scoreboard.
interface regfile_wb_arbiter_if #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // A requester holds valid and its payload steady until that edge; ready may
  // depend combinationally on valid but never the other way round.
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_data;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] busy;
  logic            wb_err;
  logic            last_grant;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output rsv_valid, rsv_addr,
    input  a_ready, b_ready, rsv_ready,
    input  wr_en, wr_addr, wr_data, busy, wb_err, last_grant
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  rsv_valid, rsv_addr,
    output a_ready, b_ready, rsv_ready,
    output wr_en, wr_addr, wr_data, busy, wb_err, last_grant
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A)
// and load unit (B), with a busy scoreboard guarding destination reservations.
module regfile_wb_arbiter #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NA = 1 << AW;

  // last_b is the round-robin pointer, exported as last_grant (1 = B granted last).
  logic            last_b;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [NREG-1:0] busy_q;
  logic            wb_err_q;

  logic            a_win;
  logic            b_win;
  logic            w_xfer;
  logic            w_legal;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            rsv_xfer;
  logic [NA-1:0]   busy_ext;
  logic [NA-1:0]   busy_nxt_ext;

  assign a_win  = bus.a_valid & (~bus.b_valid | last_b);
  assign b_win  = bus.b_valid & (~bus.a_valid | ~last_b);
  assign w_xfer = ~rst & (bus.a_valid | bus.b_valid);
  assign w_addr = a_win ? bus.a_addr : bus.b_addr;
  assign w_data = a_win ? bus.a_data : bus.b_data;
  assign w_legal = int'(w_addr) < NREG;

  // Scoreboard is widened to the full address space; bits at or above NREG
  // read as 0 and are discarded on update, so illegal addresses are ignored.
  always_comb begin
    busy_ext = '0;
    busy_ext[NREG-1:0] = busy_q;
  end

  assign rsv_xfer = bus.rsv_valid & ~rst & ~busy_ext[bus.rsv_addr];

  // Clear before set so a same-edge reservation of the written register wins.
  always_comb begin
    busy_nxt_ext = busy_ext;
    if (w_xfer) busy_nxt_ext[w_addr] = 1'b0;
    if (rsv_xfer) busy_nxt_ext[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      wr_en_q  <= w_xfer;
      wb_err_q <= w_xfer & w_legal & ~busy_ext[w_addr];
      busy_q   <= busy_nxt_ext[NREG-1:0];
      if (w_xfer) begin
        wr_addr_q <= w_addr;
        wr_data_q <= w_data;
        last_b    <= b_win;
      end
    end
  end

  assign bus.a_ready    = ~rst & a_win;
  assign bus.b_ready    = ~rst & b_win;
  assign bus.rsv_ready  = ~rst & ~busy_ext[bus.rsv_addr];
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.wb_err     = wb_err_q;
  assign bus.last_grant = last_b;
endmodule
